sur_origin_stream: RTL

- Inverse-direction companion to the down-left move generator.
- Takes a 32-bit landing-square mask produced by down-left steps and shifts it up-right N times to recover the origin squares. It then masks the result with the mover's piece set.
- Streams each origin square index out one per handshake.
- Sits between move generation and the CPU move-select logic, which consumes indices via valid/ready.

---
 rtl/sur_origin_stream_pkg.sv | 21 ++
 rtl/sur_origin_stream_sur.sv | 22 ++
 rtl/sur_origin_stream.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sur_origin_stream_pkg.sv
// Shared board definitions for the up-right trace-back stream: geometry
// constants, controller states and a row-parity helper.
package sur_origin_stream_pkg;

    localparam int BOARD_W = 32;
    localparam int ROW_SQ  = 4;
    localparam int IDX_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        STREAM,
        DONE
    } state_e;

    // Odd rows have their dark squares offset one file to the right of even rows.
    function automatic logic is_odd_row(input int sq);
        return ((sq / ROW_SQ) % 2) == 1;
    endfunction

endpackage

// File: rtl/sur_origin_stream_sur.sv
// Combinational up-right step of a 32-square dark-square board mask; squares
// that would leave the board are dropped, never wrapped.
module sur_origin_stream_sur
    import sur_origin_stream_pkg::*;
(
    input  logic [BOARD_W-1:0] board_i,
    output logic [BOARD_W-1:0] board_o
);

    // Row 0 has no row above it, so the loop starts at row 1.
    always_comb begin
        board_o = '0;
        for (int s = ROW_SQ; s < BOARD_W; s++) begin
            if (!is_odd_row(s)) begin
                board_o[s - ROW_SQ] = board_i[s];
            end else if ((s % ROW_SQ) != ROW_SQ - 1) begin
                board_o[s - ROW_SQ + 1] = board_i[s];
            end
        end
    end

endmodule

// File: rtl/sur_origin_stream.sv
// Traces landing squares back up-right N steps, masks them with the mover's
// pieces and streams each origin square index over a valid/ready handshake.
module sur_origin_stream
    import sur_origin_stream_pkg::*;
#(
    parameter int STEP_W = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [STEP_W-1:0]  steps,
    input  logic [BOARD_W-1:0] dest_mask,
    input  logic [BOARD_W-1:0] piece_mask,
    output logic               busy,
    output logic [BOARD_W-1:0] origin_mask,
    output logic               idx_valid,
    output logic [IDX_W-1:0]   idx,
    input  logic               idx_ready,
    output logic               done
);

    state_e             state_q, state_d;
    logic [BOARD_W-1:0] work_q, work_d;
    logic [BOARD_W-1:0] pm_q, pm_d;
    logic [BOARD_W-1:0] origin_q, origin_d;
    logic [STEP_W-1:0]  cnt_q, cnt_d;
    logic [BOARD_W-1:0] work_sur;
    logic [BOARD_W-1:0] low_bit;
    logic [BOARD_W-1:0] work_left;
    logic [IDX_W-1:0]   low_idx;
    logic               handshake;

    sur_origin_stream_sur u_sur (
        .board_i (work_q),
        .board_o (work_sur)
    );

    // NOTE: combinational blocks use blocking '=' with a default first, so the
    // last matching assignment wins and no latch is inferred.
    always_comb begin
        low_idx = '0;
        for (int i = BOARD_W - 1; i >= 0; i--) begin
            if (work_q[i]) low_idx = IDX_W'(i);
        end
        low_bit          = '0;
        low_bit[low_idx] = 1'b1;
    end

    assign handshake = idx_valid && idx_ready;
    assign work_left = handshake ? (work_q & ~low_bit) : work_q;

    // NOTE: sequential state uses non-blocking '<=' and every register,
    // datapath included, is cleared by the asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = STREAM;
            STREAM:  if (work_left == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        idx_valid = (state_q == STREAM) && (work_q != '0);
        idx       = idx_valid ? low_idx : '0;
        done      = (state_q == DONE);
    end

    assign origin_mask = origin_q;

    always_comb begin
        work_d   = work_q;
        cnt_d    = cnt_q;
        pm_d     = pm_q;
        origin_d = origin_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = dest_mask;
                    cnt_d  = steps;
                    pm_d   = piece_mask;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    work_d = work_sur;
                    cnt_d  = cnt_q - STEP_W'(1);
                end else begin
                    work_d   = work_q & pm_q;
                    origin_d = work_q & pm_q;
                end
            end
            STREAM:  work_d = work_left;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work_q   <= '0;
            cnt_q    <= '0;
            pm_q     <= '0;
            origin_q <= '0;
        end else begin
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            pm_q     <= pm_d;
            origin_q <= origin_d;
        end
    end

endmodule
